// File: rtl/cordic_job_queue.sv
// Job/result queueing around a CORDIC core: job FIFO toward the core, in-flight
// control FIFO tracking issued jobs, result FIFO back to the bus.

module cordic_job_queue_fifo #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata,
  output logic [$clog2(D):0]    count,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned A = $clog2(D);
  localparam logic [A:0] FULL_COUNT = (A+1)'(D);

  logic [W-1:0] mem [D];
  logic [A-1:0] wr_ptr;
  logic [A-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      // flush by snapping the write pointer to the read pointer so the head word holds
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
endmodule

module cordic_job_queue #(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [P_WIDTH-1:0] x_in,
  input  logic signed [P_WIDTH-1:0] y_in,
  input  logic signed [P_WIDTH-1:0] z_in,
  input  logic        [P_WIDTH-1:0] ctrl_in,
  output logic                      job_valid,
  input  logic                      job_ready,
  output logic signed [P_WIDTH-1:0] job_x,
  output logic signed [P_WIDTH-1:0] job_y,
  output logic signed [P_WIDTH-1:0] job_z,
  output logic        [P_WIDTH-1:0] job_ctrl,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic signed [P_WIDTH-1:0] res_x,
  input  logic signed [P_WIDTH-1:0] res_y,
  input  logic signed [P_WIDTH-1:0] res_z,
  input  logic        [P_WIDTH-1:0] res_ctrl,
  input  logic        [P_WIDTH-1:0] res_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [P_WIDTH-1:0] x_out,
  output logic signed [P_WIDTH-1:0] y_out,
  output logic signed [P_WIDTH-1:0] z_out,
  output logic        [P_WIDTH-1:0] ctrl_out,
  output logic        [P_WIDTH-1:0] status
);
  localparam int unsigned C = $clog2(P_DEPTH) + 1;

  logic               run;
  logic               err;
  logic [C-1:0]       job_cnt, fl_cnt, res_cnt;
  logic               job_full, job_empty, fl_full, fl_empty, res_full, res_empty;
  logic [4*P_WIDTH-1:0] job_head, res_head, res_word;
  logic [P_WIDTH-1:0] fl_head, merged_ctrl;
  logic               push_job, issue, res_take, res_ok, pop_out;

  // run keeps the ready outputs low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  assign in_ready  = run & ~job_full & ~clear;
  assign job_valid = run & ~job_empty & ~fl_full & ~clear;
  assign res_ready = run & ~res_full & ~clear;
  assign out_valid = run & ~res_empty & ~clear;

  assign push_job = in_valid & in_ready;
  assign issue    = job_valid & job_ready;
  assign res_take = res_valid & res_ready;
  assign res_ok   = res_take & ~fl_empty;
  assign pop_out  = out_valid & out_ready;

  assign merged_ctrl = (fl_head & ~res_mask) | (res_ctrl & res_mask);
  assign res_word    = {res_x, res_y, res_z, merged_ctrl};

  cordic_job_queue_fifo #(.W(4*P_WIDTH), .D(P_DEPTH)) u_job_fifo (
    .clk(clk), .rst(rst), .clear(clear), .push(push_job), .pop(issue),
    .wdata({x_in, y_in, z_in, ctrl_in}), .rdata(job_head), .count(job_cnt),
    .full(job_full), .empty(job_empty)
  );

  cordic_job_queue_fifo #(.W(P_WIDTH), .D(P_DEPTH)) u_flight_fifo (
    .clk(clk), .rst(rst), .clear(clear), .push(issue), .pop(res_ok),
    .wdata(job_ctrl), .rdata(fl_head), .count(fl_cnt),
    .full(fl_full), .empty(fl_empty)
  );

  cordic_job_queue_fifo #(.W(4*P_WIDTH), .D(P_DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .clear(clear), .push(res_ok), .pop(pop_out),
    .wdata(res_word), .rdata(res_head), .count(res_cnt),
    .full(res_full), .empty(res_empty)
  );

  assign {job_x, job_y, job_z, job_ctrl} = job_head;
  assign {x_out, y_out, z_out, ctrl_out} = res_head;

  // a result arriving with nothing in flight is dropped and flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      err <= 1'b0;
    else if (clear)                err <= 1'b0;
    else if (res_take && fl_empty) err <= 1'b1;
  end

  always_comb begin
    status              = '0;
    status[C-1:0]       = job_cnt;
    status[2*C-1:C]     = fl_cnt;
    status[3*C-1:2*C]   = res_cnt;
    status[P_WIDTH-1]   = err;
  end
endmodule

// File: tb/tb_cordic_job_queue.sv
// Bench for cordic_job_queue: directed scenarios plus randomized traffic,
// checked each cycle against a queue-based transaction model.

module tb_cordic_job_queue;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] c;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0, job_ready = 1'b0, res_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, job_valid, res_ready, out_valid;
  logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic [W-1:0] ctrl_in = '0;
  logic signed [W-1:0] res_x = '0, res_y = '0, res_z = '0;
  logic [W-1:0] res_ctrl = '0, res_mask = '0;
  logic signed [W-1:0] job_x, job_y, job_z, x_out, y_out, z_out;
  logic [W-1:0] job_ctrl, ctrl_out, status;

  int n_vec = 0;
  int n_err = 0;

  job_t jq[$];
  job_t rq[$];
  logic [W-1:0] fq[$];
  bit merr = 1'b0;

  cordic_job_queue #(.P_WIDTH(W), .P_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .ctrl_in(ctrl_in),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z), .job_ctrl(job_ctrl),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_ctrl(res_ctrl), .res_mask(res_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .ctrl_out(ctrl_out),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_job_valid"}, job_valid, 0);
    check({tag, "_res_ready"}, res_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_status"}, status, 0);
    check({tag, "_job_x"}, job_x, 0);
    check({tag, "_job_ctrl"}, job_ctrl, 0);
    check({tag, "_x_out"}, x_out, 0);
    check({tag, "_ctrl_out"}, ctrl_out, 0);
  endtask

  task automatic model_flush();
    jq.delete();
    fq.delete();
    rq.delete();
    merr = 1'b0;
  endtask

  task automatic idle();
    in_valid = 0; job_ready = 0; res_valid = 0; out_ready = 0; clear = 0;
  endtask

  task automatic rand_job();
    x_in = $urandom; y_in = $urandom; z_in = $urandom; ctrl_in = $urandom;
  endtask

  task automatic rand_res();
    res_x = $urandom; res_y = $urandom; res_z = $urandom;
    res_ctrl = $urandom; res_mask = $urandom;
  endtask

  // One clock: check DUT against the model, then advance the model on the edge.
  task automatic cycle();
    bit m_in_rdy, m_job_v, m_res_rdy, m_out_v;
    logic [W-1:0] st;
    logic [W-1:0] inflight;
    job_t j;
    #2;
    m_in_rdy  = (jq.size() < D) && !clear;
    m_job_v   = (jq.size() != 0) && (fq.size() < D) && !clear;
    m_res_rdy = (rq.size() < D) && !clear;
    m_out_v   = (rq.size() != 0) && !clear;
    check("in_ready", in_ready, m_in_rdy);
    check("job_valid", job_valid, m_job_v);
    check("res_ready", res_ready, m_res_rdy);
    check("out_valid", out_valid, m_out_v);
    if (m_job_v) begin
      check("job_x", job_x, jq[0].x);
      check("job_y", job_y, jq[0].y);
      check("job_z", job_z, jq[0].z);
      check("job_ctrl", job_ctrl, jq[0].c);
    end
    if (m_out_v) begin
      check("x_out", x_out, rq[0].x);
      check("y_out", y_out, rq[0].y);
      check("z_out", z_out, rq[0].z);
      check("ctrl_out", ctrl_out, rq[0].c);
    end
    st = '0;
    st[2:0] = 3'(jq.size());
    st[5:3] = 3'(fq.size());
    st[8:6] = 3'(rq.size());
    st[W-1] = merr;
    check("status", status, st);
    @(posedge clk);
    if (clear) begin
      model_flush();
    end else begin
      if (out_ready && m_out_v) void'(rq.pop_front());
      if (res_valid && m_res_rdy) begin
        if (fq.size() != 0) begin
          inflight = fq.pop_front();
          j.x = res_x; j.y = res_y; j.z = res_z;
          j.c = (inflight & ~res_mask) | (res_ctrl & res_mask);
          rq.push_back(j);
        end else begin
          merr = 1'b1;
        end
      end
      if (job_ready && m_job_v) begin
        j = jq.pop_front();
        fq.push_back(j.c);
      end
      if (in_valid && m_in_rdy) begin
        j.x = x_in; j.y = y_in; j.z = z_in; j.c = ctrl_in;
        jq.push_back(j);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset
    #2;
    check_reset_outputs("por");
    @(posedge clk); #1;
    check_reset_outputs("por_edge");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, 1);
    check("res_ready_first_edge", res_ready, 1);
    @(negedge clk);

    // Single job through issue
    idle();
    in_valid = 1; job_ready = 1;
    x_in = 1; y_in = 2; z_in = 3; ctrl_in = 32'h10;
    cycle();
    in_valid = 0;
    cycle();
    check("inflight_after_issue", status[5:3], 1);
    res_valid = 1; rand_res();
    cycle();
    res_valid = 0; out_ready = 1;
    cycle();
    cycle();

    // Control-word merge
    idle();
    in_valid = 1; job_ready = 1; ctrl_in = 32'hF0; x_in = -5; y_in = 7; z_in = 9;
    cycle();
    in_valid = 0;
    cycle();
    job_ready = 0; res_valid = 1; res_ctrl = 32'h0F; res_mask = 32'h0C;
    res_x = 11; res_y = -12; res_z = 13;
    cycle();
    res_valid = 0;
    check("ctrl_merge", ctrl_out, 32'hFC);
    out_ready = 1;
    cycle();

    // Job FIFO fills at depth
    idle();
    job_ready = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rand_job();
      cycle();
    end
    check("job_full_in_ready", in_ready, 0);
    check("job_full_count", status[2:0], 4);
    in_valid = 0; clear = 1;
    cycle();
    clear = 0;

    // Orphan result sets sticky error, clear wipes it
    res_valid = 1; rand_res();
    cycle();
    res_valid = 0;
    check("orphan_err", status[W-1], 1);
    check("orphan_no_out", out_valid, 0);
    cycle();
    clear = 1;
    cycle();
    clear = 0;
    check("status_after_clear", status, 0);
    cycle();

    // Back-pressure through the full pipeline, then drain in order
    idle();
    in_valid = 1; job_ready = 1; out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      rand_job(); rand_res();
      res_valid = (fq.size() != 0);
      cycle();
    end
    check("stall_res_ready", res_ready, 0);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      rand_res();
      res_valid = (fq.size() != 0);
      cycle();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      job_ready = ($urandom_range(0, 2) != 0);
      res_valid = ($urandom_range(0, 3) != 0);
      out_ready = ((i % 80) < 30) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      rand_job(); rand_res();
      cycle();
    end

    // Reset in mid-stream
    idle();
    in_valid = 1; job_ready = 1; out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      rand_job(); rand_res();
      res_valid = (fq.size() != 0) && (i % 2 == 1);
      cycle();
    end
    res_valid = 1; out_ready = 1;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_flush();
    @(posedge clk); #1;
    check_reset_outputs("mid_rst_edge");
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      job_ready = ($urandom_range(0, 1) != 0);
      res_valid = (fq.size() != 0) && ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_job(); rand_res();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
